// File: rtl/linebuffer_multi.sv
// -----------------------------------------------------------------------------
// linebuffer_multi
//
// Multi-line video line buffer. Stores the previous NUM_LINES lines of a raster
// stream in one single-port RAM per line and presents a column-aligned vertical
// tap vector: tap 0 is the current pixel, tap k is the pixel in the same column
// k lines earlier. Supports a runtime line length, frame-start resync on `sof`,
// and gaps in `in_valid`.
//
// Parameters:
//   ADDR_WIDTH - column address width (2**ADDR_WIDTH >= LENGTH)
//   DATA_WIDTH - pixel width
//   LENGTH     - maximum line length / depth of each line RAM
//   NUM_LINES  - number of stored lines (1..8)
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   synchronous active-low reset
//   data_in   in   input pixel
//   in_valid  in   data_in valid this cycle
//   sof       in   start of frame (qualified by in_valid)
//   line_len  in   active pixels per line, sampled on an accepted sof pixel
//   data_out  out  tap vector, slice k = tap k
//   out_valid out  data_out valid
//   eol_out   out  output pixel is the last column of its line
//   cfg_err   out  one-cycle pulse: sampled line_len was 0 or > LENGTH
//
// Build option:
//   LB_ZERO_FILL_EN - when defined, outputs are valid from the first line of a
//   frame and taps for lines not yet written this frame read as 0. When
//   undefined, out_valid is held low until NUM_LINES lines have been stored.
// -----------------------------------------------------------------------------
module linebuffer_multi #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 16,
    parameter int LENGTH     = 1920,
    parameter int NUM_LINES  = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                in_valid,
    input  logic                                sof,
    input  logic [ADDR_WIDTH-1:0]               line_len,
    output logic [(NUM_LINES+1)*DATA_WIDTH-1:0] data_out,
    output logic                                out_valid,
    output logic                                eol_out,
    output logic                                cfg_err
);

    localparam int SEL_W  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam int DONE_W = $clog2(NUM_LINES + 1);
    // One extra bit so LENGTH itself is representable even when it equals
    // 2**ADDR_WIDTH.
    localparam int LEN_W  = ADDR_WIDTH + 1;
    localparam int RAM_AW = (LENGTH > 1) ? $clog2(LENGTH) : 1;

`ifdef LB_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    // Fill / position state
    logic [ADDR_WIDTH-1:0] col_reg;
    logic [SEL_W-1:0]      wr_sel_reg;
    logic [DONE_W-1:0]     lines_done_reg;
    logic [LEN_W-1:0]      len_q_reg;

    // Per-pixel registers travelling alongside the RAM read data
    logic [DATA_WIDTH-1:0] pix_reg;
    logic [SEL_W-1:0]      sel_q_reg;
    logic [DONE_W-1:0]     done_q_reg;
    logic [DATA_WIDTH-1:0] rd_reg [NUM_LINES];

    logic                  accept;
    logic                  sof_acc;
    logic                  len_bad;
    logic                  wrap;
    logic                  emit;
    logic [ADDR_WIDTH-1:0] eff_col;
    logic [SEL_W-1:0]      eff_sel;
    logic [DONE_W-1:0]     eff_done;
    logic [LEN_W-1:0]      eff_len;
    logic [ADDR_WIDTH-1:0] col_next;
    logic [SEL_W-1:0]      sel_next;
    logic [DONE_W-1:0]     done_next;
    logic [RAM_AW-1:0]     ram_addr;

    assign accept  = in_valid;
    assign sof_acc = in_valid & sof;
    assign len_bad = (line_len == '0) || ({1'b0, line_len} > LEN_W'(LENGTH));

    // An accepted sof overrides the running state for this very pixel, so the
    // sof pixel is treated as column 0 of line 0 with the freshly sampled length.
    always_comb begin
        eff_col  = sof_acc ? '0 : col_reg;
        eff_sel  = sof_acc ? '0 : wr_sel_reg;
        eff_done = sof_acc ? '0 : lines_done_reg;
        eff_len  = len_q_reg;
        if (sof_acc) begin
            eff_len = len_bad ? LEN_W'(LENGTH) : {1'b0, line_len};
        end
        wrap      = ({1'b0, eff_col} == eff_len - LEN_W'(1));
        col_next  = wrap ? '0 : eff_col + ADDR_WIDTH'(1);
        sel_next  = eff_sel;
        if (wrap) begin
            sel_next = (eff_sel == SEL_W'(NUM_LINES - 1)) ? '0 : eff_sel + SEL_W'(1);
        end
        done_next = (wrap && (eff_done != DONE_W'(NUM_LINES))) ? eff_done + DONE_W'(1) : eff_done;
        emit      = accept && (ZERO_FILL || (eff_done == DONE_W'(NUM_LINES)));
        ram_addr  = eff_col[RAM_AW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_reg        <= '0;
            wr_sel_reg     <= '0;
            lines_done_reg <= '0;
            len_q_reg      <= LEN_W'(LENGTH);
            pix_reg        <= '0;
            sel_q_reg      <= '0;
            done_q_reg     <= '0;
            out_valid      <= 1'b0;
            eol_out        <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            if (accept) begin
                col_reg        <= col_next;
                wr_sel_reg     <= sel_next;
                lines_done_reg <= done_next;
                len_q_reg      <= eff_len;
                pix_reg        <= data_in;
                // Capture the pre-wrap selector so the taps of this pixel are
                // resolved against the RAM it was written into.
                sel_q_reg      <= eff_sel;
                done_q_reg     <= eff_done;
            end
            out_valid <= emit;
            eol_out   <= emit && wrap;
            cfg_err   <= sof_acc && len_bad;
        end
    end

    // One read-first single-port RAM per stored line.
    genvar gi, gj;
    generate
        for (gi = 0; gi < NUM_LINES; gi++) begin : g_ram
            logic [DATA_WIDTH-1:0] mem [LENGTH];

            always_ff @(posedge clk) begin
                if (rst_n && accept && (eff_sel == SEL_W'(gi))) begin
                    mem[ram_addr] <= data_in;
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_reg[gi] <= '0;
                end else if (accept) begin
                    rd_reg[gi] <= mem[ram_addr];
                end
            end
        end

        assign data_out[DATA_WIDTH-1:0] = pix_reg;

        // Tap k comes from RAM (sel - k) mod NUM_LINES; built as an AND-OR mux
        // over every possible selector value so all indices are constants.
        for (gi = 1; gi <= NUM_LINES; gi++) begin : g_tap
            logic [DATA_WIDTH-1:0] chain [NUM_LINES+1];
            assign chain[0] = '0;
            for (gj = 0; gj < NUM_LINES; gj++) begin : g_src
                assign chain[gj+1] = chain[gj] |
                    ((sel_q_reg == SEL_W'(gj)) ? rd_reg[(gj + NUM_LINES - gi) % NUM_LINES] : '0);
            end
            // Lines not yet written in this frame are masked in zero-fill mode.
            assign data_out[gi*DATA_WIDTH +: DATA_WIDTH] =
                (ZERO_FILL && (DONE_W'(gi) > done_q_reg)) ? '0 : chain[NUM_LINES];
        end
    endgenerate

endmodule

// File: doc/linebuffer_multi.md
# linebuffer_multi

Multi-line video line buffer that stores the previous NUM_LINES lines of a raster stream and presents a column-aligned vertical tap vector (current pixel plus same-column pixels from 1..NUM_LINES lines earlier) for downstream 2-D window filters. It generalises the two-RAM ping-pong line buffer to a parameterised number of lines, adds a runtime line length and frame-start resynchronisation, and tolerates gaps in `in_valid`. It sits between the pixel input stage and the window/convolution logic.

## Interface
- `ADDR_WIDTH`, 11, column address width; must satisfy 2^ADDR_WIDTH >= LENGTH.
- `DATA_WIDTH`, 16, pixel width.
- `LENGTH`, 1920, maximum line length and depth of each line RAM.
- `NUM_LINES`, 2, number of stored lines, range 1..8; one single-port RAM per line.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `data_in`  in  DATA_WIDTH  input pixel.
- `in_valid`  in  1  `data_in` valid this cycle; one pixel accepted per asserted cycle.
- `sof`  in  1  start of frame; qualified by `in_valid`; marks the pixel as column 0 of line 0.
- `line_len`  in  ADDR_WIDTH  active pixels per line; sampled only on an accepted `sof` pixel.
- `data_out`  out  (NUM_LINES+1)*DATA_WIDTH  tap vector; bits [DATA_WIDTH-1:0] = tap 0 (current pixel), slice k = tap k (same column, k lines earlier).
- `out_valid`  out  1  `data_out` valid.
- `eol_out`  out  1  qualifies `out_valid`; output pixel is the last column of its line.
- `cfg_err`  out  1  one-cycle pulse: sampled `line_len` was 0 or > LENGTH.

## Operation
- Column counter `col` (0..len_q-1) advances on each accepted pixel; wraps to 0 after `len_q-1`; holds while `in_valid`=0.
- `len_q` resets to LENGTH; on accepted `sof`, loads `line_len`, or LENGTH with `cfg_err`=1 if the value is out of range.
- Write selector `wr_sel` (0..NUM_LINES-1) increments mod NUM_LINES at each line wrap; RAM `wr_sel` receives the current line.
- Every accepted pixel reads all RAMs at `col` (read-first: old contents returned) and writes `data_in` into RAM `wr_sel` at `col`.
- Tap k (1..NUM_LINES) is taken from RAM `(wr_sel - k) mod NUM_LINES`. Tap NUM_LINES is the RAM being overwritten, using its pre-write data.
- Tap select and `wr_sel` are registered with the pixel, so a line wrap never misaligns taps.
- Fill counter `lines_done` increments at each line wrap and saturates at NUM_LINES.
- Accepted `sof` forces `col`=0, `wr_sel`=0 and `lines_done`=0 for that pixel, then proceeds normally. A `sof` mid-line truncates the partial line; no output is produced for the lost columns.
- `sof` with `in_valid`=0 is ignored.

## Timing
- Latency: `data_out`, `out_valid` and `eol_out` are registered one cycle after the accepted pixel. Every accepted pixel yields exactly one output cycle once valid.
- No backpressure; the downstream stage must accept every `out_valid` cycle.
- Reset values: `data_out`=0, `out_valid`=0, `eol_out`=0, `cfg_err`=0. Internal state after reset: `col`=0, `wr_sel`=0, `lines_done`=0, `len_q`=LENGTH.
- Reset mid-line discards all fill state. RAM contents are not cleared.
- `cfg_err` is asserted in the same cycle as the output for the `sof` pixel.

## Configuration
- `LB_ZERO_FILL_EN` defined:
  - `out_valid` follows every accepted pixel from the first line of a frame.
  - Taps k > `lines_done` (lines not yet written this frame) output 0.
- `LB_ZERO_FILL_EN` undefined:
  - `out_valid` is asserted only for pixels accepted while `lines_done`==NUM_LINES.
  - Before that, taps output unmasked RAM data, which is don't-care.

## Test plan
All scenarios use NUM_LINES=2, LENGTH=8, `line_len`=4, `sof` on the first pixel, pixels 0,1,2,…, and continuous `in_valid` unless stated.
- Fill, macro undefined: `out_valid` stays 0 for pixels 0..7. First valid output, one cycle after pixel 8, is taps {8,4,0}, then {9,5,1}. `eol_out`=1 with {11,7,3}.
- Steady state: at pixel 13 output {13,9,5}. Across the wrap from 15 to 16, taps are {15,11,7} then {16,12,8} with no bubble.
- Gaps: `in_valid` toggled 1,0,1,0 during line 2 gives outputs matching the continuous case, with `out_valid` low in the gap cycles.
- Mid-line `sof`: after pixel 9, assert `sof` on pixel 100. Outputs are invalid until 2 full new lines are stored; then the first output is {108,104,100}.
- Config error: `line_len`=0, then `line_len`=9. Each gives `cfg_err`=1 for one cycle, and the wrap occurs after 8 pixels (col 7).
- `LB_ZERO_FILL_EN` defined: pixel 0 gives {0,0,0} with `out_valid`=1; pixel 5 gives {5,1,0}; pixel 9 gives {9,5,1}.
